// File: rtl/pwm_pkg.sv
// Shared types and the round-robin search helper for the PWM capture scheduler.
package pwm_pkg;

  localparam int unsigned PWM_MAX_CH   = 16;
  localparam int unsigned PWM_MAX_CH_W = 4;
  localparam int unsigned PWM_RES_W    = 16;

  typedef enum logic [2:0] {
    S_IDLE,
    S_SELECT,
    S_ARM,
    S_WAIT_EDGE,
    S_HIGH,
    S_LOW,
    S_STORE
  } sched_state_t;

  typedef struct packed {
    logic [PWM_RES_W-1:0] high_time;
    logic [PWM_RES_W-1:0] period;
    logic                 timeout;
  } pwm_result_t;

  // First set bit of mask at or after start, wrapping modulo nch; MSB = found.
  function automatic logic [PWM_MAX_CH_W:0] rr_next(
    input logic [PWM_MAX_CH-1:0]   mask,
    input logic [PWM_MAX_CH_W-1:0] start,
    input int unsigned             nch
  );
    logic [PWM_MAX_CH_W:0] res;
    int unsigned           idx;
    res = '0;
    for (int unsigned i = 0; i < PWM_MAX_CH; i++) begin
      idx = (32'(start) + i) % nch;
      if ((i < nch) && !res[PWM_MAX_CH_W] && mask[PWM_MAX_CH_W'(idx)]) begin
        res = {1'b1, PWM_MAX_CH_W'(idx)};
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/pwm_sched_rr.sv
// Combinational round-robin picker: next set bit of mask after cur_i (or from 0 when restart_i).
module pwm_sched_rr
  import pwm_pkg::*;
#(
  parameter int unsigned K_NCH = 4,
  parameter int unsigned K_CW  = $clog2(K_NCH)
) (
  input  logic [K_NCH-1:0] mask_i,
  input  logic [K_CW-1:0]  cur_i,
  input  logic             restart_i,
  output logic [K_CW-1:0]  next_c_o,
  output logic             none_c_o
);

  logic [PWM_MAX_CH_W-1:0] start;
  logic [PWM_MAX_CH_W:0]   pick;

  always_comb begin
    start    = restart_i ? '0 : PWM_MAX_CH_W'((32'(cur_i) + 32'd1) % K_NCH);
    pick     = rr_next(PWM_MAX_CH'(mask_i), start, K_NCH);
    next_c_o = K_CW'(pick);
    none_c_o = ~pick[PWM_MAX_CH_W];
  end

endmodule

// File: rtl/pwm_capture_sched.sv
// Round-robin PWM high-time/period capture shared across K_NCH inputs.
// Optional timeout abort enabled by defining PWM_SCHED_TIMEOUT_EN.
module pwm_capture_sched
  import pwm_pkg::*;
#(
  parameter int unsigned         K_NCH     = 4,
  parameter int unsigned         K_DWIDTH  = 16,
  parameter logic [K_DWIDTH-1:0] K_TIMEOUT = 16'hFFFF
) (
  input  logic                       i_clk,
  input  logic                       i_rst_n,
  input  logic                       i_timebase,
  input  logic [K_NCH-1:0]           i_pwm,
  input  logic [K_NCH-1:0]           i_polarity,
  input  logic [K_NCH-1:0]           i_enable,
  input  logic [K_NCH-1:0]           i_ack,
  output logic                       o_busy,
  output logic [$clog2(K_NCH)-1:0]   o_chan,
  output logic                       o_valid,
  output logic [$clog2(K_NCH)-1:0]   o_valid_chan,
  output logic [K_DWIDTH-1:0]        o_high_time,
  output logic [K_DWIDTH-1:0]        o_period,
  output logic                       o_timeout,
  output logic [K_NCH-1:0]           o_fresh
);

  localparam int unsigned CW = $clog2(K_NCH);

  if ((K_NCH < 2) || (K_NCH > PWM_MAX_CH) || (K_DWIDTH < 1) || (K_DWIDTH > PWM_RES_W)
      || (K_TIMEOUT == '0)) begin : g_bad_param
    $error("pwm_capture_sched: unsupported parameter set");
  end

  sched_state_t         state_q;
  logic [CW-1:0]        chan_q;
  logic                 first_q;
  logic                 busy_q;
  logic                 valid_q;
  logic [CW-1:0]        vchan_q;
  pwm_result_t          res_q;
  logic [K_NCH-1:0]     fresh_q;
  logic [K_DWIDTH-1:0]  high_q;
  logic [K_DWIDTH-1:0]  low_q;

  logic                 lvl_c;
  logic                 en_c;
  logic                 meas_c;
  logic                 abort_c;
  logic                 tmo_hit_c;
  logic                 tmo_c;
  logic                 done_c;
  logic                 pub_c;
  logic [K_DWIDTH-1:0]  high_inc_c;
  logic [K_DWIDTH-1:0]  low_inc_c;
  logic [K_DWIDTH:0]    sum_c;
  logic [K_DWIDTH-1:0]  period_c;
  logic [K_NCH-1:0]     set_c;
  logic [CW-1:0]        pick_c;
  logic                 none_c;

  pwm_sched_rr #(
    .K_NCH (K_NCH),
    .K_CW  (CW)
  ) u_rr (
    .mask_i    (i_enable),
    .cur_i     (chan_q),
    .restart_i (first_q),
    .next_c_o  (pick_c),
    .none_c_o  (none_c)
  );

`ifdef PWM_SCHED_TIMEOUT_EN
  logic [K_DWIDTH-1:0] tmo_q;

  // Watchdog: cleared on each channel selection, counts every tick while measuring.
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      tmo_q <= '0;
    end else if (state_q == S_SELECT) begin
      tmo_q <= '0;
    end else if (meas_c && i_timebase) begin
      tmo_q <= tmo_q + 1'b1;
    end
  end

  assign tmo_hit_c = meas_c && i_timebase && (K_DWIDTH'(tmo_q + 1'b1) == K_TIMEOUT);
`else
  assign tmo_hit_c = 1'b0;
`endif

  always_comb begin
    lvl_c      = i_pwm[chan_q] ^ i_polarity[chan_q];
    en_c       = i_enable[chan_q];
    meas_c     = (state_q == S_ARM) || (state_q == S_WAIT_EDGE) ||
                 (state_q == S_HIGH) || (state_q == S_LOW);
    abort_c    = meas_c && !en_c;
    tmo_c      = en_c && tmo_hit_c;
    done_c     = (state_q == S_LOW) && en_c && i_timebase && lvl_c && !tmo_hit_c;
    pub_c      = tmo_c || done_c;
    high_inc_c = (&high_q) ? high_q : high_q + 1'b1;
    low_inc_c  = (&low_q) ? low_q : low_q + 1'b1;
    sum_c      = {1'b0, high_q} + {1'b0, low_q};
    period_c   = sum_c[K_DWIDTH] ? '1 : sum_c[K_DWIDTH-1:0];
    // Set is applied both on the closing tick and in STORE so a colliding ack never wins.
    set_c      = (pub_c || (state_q == S_STORE)) ? (K_NCH'(1) << chan_q) : '0;
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      state_q <= S_IDLE;
      chan_q  <= '0;
      first_q <= 1'b1;
      busy_q  <= 1'b0;
      valid_q <= 1'b0;
      vchan_q <= '0;
      res_q   <= '0;
      fresh_q <= '0;
      high_q  <= '0;
      low_q   <= '0;
    end else begin
      busy_q  <= (state_q != S_IDLE);
      valid_q <= 1'b0;
      fresh_q <= (fresh_q & ~i_ack) | set_c;

      if (done_c) begin
        valid_q <= 1'b1;
        vchan_q <= chan_q;
        res_q   <= '{high_time: PWM_RES_W'(high_q), period: PWM_RES_W'(period_c), timeout: 1'b0};
      end else if (tmo_c) begin
        valid_q <= 1'b1;
        vchan_q <= chan_q;
        res_q   <= '{high_time: PWM_RES_W'({K_DWIDTH{lvl_c}}), period: '0, timeout: 1'b1};
      end

      unique case (state_q)
        S_IDLE: begin
          if (|i_enable) state_q <= S_SELECT;
        end
        S_SELECT: begin
          if (none_c) begin
            state_q <= S_IDLE;
          end else begin
            chan_q  <= pick_c;
            first_q <= 1'b0;
            state_q <= S_ARM;
          end
        end
        S_ARM: begin
          if (abort_c)                  state_q <= S_SELECT;
          else if (tmo_c)               state_q <= S_STORE;
          else if (i_timebase && !lvl_c) state_q <= S_WAIT_EDGE;
        end
        S_WAIT_EDGE: begin
          if (abort_c) begin
            state_q <= S_SELECT;
          end else if (tmo_c) begin
            state_q <= S_STORE;
          end else if (i_timebase && lvl_c) begin
            // The opening edge tick is itself the first active tick.
            high_q  <= K_DWIDTH'(1);
            low_q   <= '0;
            state_q <= S_HIGH;
          end
        end
        S_HIGH: begin
          if (abort_c) begin
            state_q <= S_SELECT;
          end else if (tmo_c) begin
            state_q <= S_STORE;
          end else if (i_timebase) begin
            if (lvl_c) begin
              high_q <= high_inc_c;
            end else begin
              low_q   <= low_inc_c;
              state_q <= S_LOW;
            end
          end
        end
        S_LOW: begin
          if (abort_c) begin
            state_q <= S_SELECT;
          end else if (tmo_c || done_c) begin
            state_q <= S_STORE;
          end else if (i_timebase) begin
            low_q <= low_inc_c;
          end
        end
        S_STORE: begin
          state_q <= S_SELECT;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign o_busy       = busy_q;
  assign o_chan       = chan_q;
  assign o_valid      = valid_q;
  assign o_valid_chan = vchan_q;
  assign o_high_time  = K_DWIDTH'(res_q.high_time);
  assign o_period     = K_DWIDTH'(res_q.period);
  assign o_timeout    = res_q.timeout;
  assign o_fresh      = fresh_q;

endmodule

// File: tb/tb_pwm_capture_sched.sv
// Directed bench for pwm_capture_sched; timeout scenario selected by PWM_SCHED_TIMEOUT_EN.
module tb_pwm_capture_sched;

  logic        i_clk = 1'b0;
  logic        i_rst_n;
  logic        i_timebase;
  logic [3:0]  i_pwm, i_polarity, i_enable, i_ack;
  logic        o_busy, o_valid, o_timeout;
  logic [1:0]  o_chan, o_valid_chan;
  logic [15:0] o_high_time, o_period;
  logic [3:0]  o_fresh;

  int tests  = 0;
  int fails  = 0;
  int nvalid = 0;
  logic [1:0]  v_chan[$];
  logic [15:0] v_high[$];
  logic [15:0] v_period[$];
  logic        v_tmo[$];

  always #5 i_clk = ~i_clk;

  pwm_capture_sched #(
    .K_NCH     (4),
    .K_DWIDTH  (16),
    .K_TIMEOUT (16'd20)
  ) dut (
    .i_clk        (i_clk),
    .i_rst_n      (i_rst_n),
    .i_timebase   (i_timebase),
    .i_pwm        (i_pwm),
    .i_polarity   (i_polarity),
    .i_enable     (i_enable),
    .i_ack        (i_ack),
    .o_busy       (o_busy),
    .o_chan       (o_chan),
    .o_valid      (o_valid),
    .o_valid_chan (o_valid_chan),
    .o_high_time  (o_high_time),
    .o_period     (o_period),
    .o_timeout    (o_timeout),
    .o_fresh      (o_fresh)
  );

  // Result recorder: every sampled o_valid cycle is one published result.
  always @(negedge i_clk) begin
    if (o_valid) begin
      nvalid++;
      v_chan.push_back(o_valid_chan);
      v_high.push_back(o_high_time);
      v_period.push_back(o_period);
      v_tmo.push_back(o_timeout);
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic clk_n(input int n);
    repeat (n) @(negedge i_clk);
    #1;
  endtask

  // One timebase tick: PWM held for two clocks, i_timebase high for the first.
  task automatic tick(input logic [3:0] p);
    @(negedge i_clk);
    i_pwm      = p;
    i_timebase = 1'b1;
    @(negedge i_clk);
    i_timebase = 1'b0;
    #1;
  endtask

  task automatic test_reset;
    i_rst_n = 1'b0; i_timebase = 1'b0; i_pwm = '0; i_polarity = '0; i_enable = '0; i_ack = '0;
    clk_n(3);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL reset_busy: got %0b want 0", o_busy); end
    tests++; if (o_chan !== 2'd0) begin fails++; $display("FAIL reset_chan: got %0d want 0", o_chan); end
    tests++; if (o_valid !== 1'b0) begin fails++; $display("FAIL reset_valid: got %0b want 0", o_valid); end
    tests++; if (o_high_time !== 16'd0 || o_period !== 16'd0) begin fails++; $display("FAIL reset_result: got high %0d period %0d want 0 0", o_high_time, o_period); end
    tests++; if (o_timeout !== 1'b0 || o_fresh !== 4'b0000) begin fails++; $display("FAIL reset_flags: got tmo %0b fresh %b want 0 0000", o_timeout, o_fresh); end
    @(negedge i_clk); i_rst_n = 1'b1;
    clk_n(2);
  endtask

  task automatic test_single_channel;
    int b;
    b = nvalid;
    i_enable = 4'b0001;
    clk_n(3);
    tick(4'b0000);
    repeat (3) tick(4'b0001);
    repeat (5) tick(4'b0000);
    tick(4'b0001);
    tests++; if (nvalid - b !== 1) begin fails++; $display("FAIL single_latency: got %0d results one clk after closing tick want 1", nvalid - b); end
    tests++; if (v_chan[b] !== 2'd0) begin fails++; $display("FAIL single_chan: got %0d want 0", v_chan[b]); end
    tests++; if (v_high[b] !== 16'd3) begin fails++; $display("FAIL single_high: got %0d want 3", v_high[b]); end
    tests++; if (v_period[b] !== 16'd8) begin fails++; $display("FAIL single_period: got %0d want 8", v_period[b]); end
    tests++; if (v_tmo[b] !== 1'b0) begin fails++; $display("FAIL single_timeout: got %0b want 0", v_tmo[b]); end
    tests++; if (o_fresh !== 4'b0001) begin fails++; $display("FAIL single_fresh: got %b want 0001", o_fresh); end
    i_enable = 4'b0000;
    clk_n(4);
    tests++; if (o_busy !== 1'b0) begin fails++; $display("FAIL single_idle: busy got %0b want 0", o_busy); end
    tests++; if (nvalid - b !== 1 || o_high_time !== 16'd3) begin fails++; $display("FAIL single_hold: got %0d results high %0d want 1 result high 3", nvalid - b, o_high_time); end
    @(negedge i_clk); i_ack = 4'b0001;
    @(negedge i_clk); i_ack = 4'b0000;
    #1;
    tests++; if (o_fresh !== 4'b0000) begin fails++; $display("FAIL single_ack: fresh got %b want 0000", o_fresh); end
  endtask

  task automatic test_round_robin;
    int b;
    logic [3:0] p;
    logic [1:0] ec;
    b = nvalid;
    i_enable = 4'b1010;
    for (int k = 0; k < 200 && (nvalid - b) < 4; k++) begin
      p    = 4'b0000;
      p[1] = ((k % 4) == 0);
      p[3] = ((k % 6) < 3);
      tick(p);
    end
    i_enable = 4'b0000;
    clk_n(4);
    tests++; if (nvalid - b !== 4) begin fails++; $display("FAIL rr_count: got %0d results want 4", nvalid - b); end
    for (int i = 0; i < 4; i++) begin
      ec = (i % 2 == 0) ? 2'd1 : 2'd3;
      tests++;
      if (v_chan[b+i] !== ec || v_high[b+i] !== ((ec == 2'd1) ? 16'd1 : 16'd3) ||
          v_period[b+i] !== ((ec == 2'd1) ? 16'd4 : 16'd6)) begin
        fails++;
        $display("FAIL rr_result%0d: got chan %0d high %0d period %0d want chan %0d high %0d period %0d",
                 i, v_chan[b+i], v_high[b+i], v_period[b+i], ec,
                 (ec == 2'd1) ? 1 : 3, (ec == 2'd1) ? 4 : 6);
      end
    end
    tests++; if (o_fresh !== 4'b1010) begin fails++; $display("FAIL rr_fresh: got %b want 1010", o_fresh); end
  endtask

  task automatic test_stuck_input;
    int b;
    b = nvalid;
    i_enable = 4'b0100;
    clk_n(3);
`ifdef PWM_SCHED_TIMEOUT_EN
    repeat (19) tick(4'b0100);
    tests++; if (nvalid - b !== 0) begin fails++; $display("FAIL tmo_early: got %0d results before limit want 0", nvalid - b); end
    tick(4'b0100);
    tests++; if (nvalid - b !== 1) begin fails++; $display("FAIL tmo_count: got %0d results want 1", nvalid - b); end
    tests++; if (v_chan[b] !== 2'd2 || v_tmo[b] !== 1'b1) begin fails++; $display("FAIL tmo_flag: got chan %0d tmo %0b want 2 1", v_chan[b], v_tmo[b]); end
    tests++; if (v_high[b] !== 16'hFFFF || v_period[b] !== 16'd0) begin fails++; $display("FAIL tmo_values: got high %h period %0d want ffff 0", v_high[b], v_period[b]); end
`else
    repeat (30) tick(4'b0100);
    tests++; if (nvalid - b !== 0) begin fails++; $display("FAIL stuck_count: got %0d results want 0", nvalid - b); end
    tests++; if (o_busy !== 1'b1 || o_chan !== 2'd2) begin fails++; $display("FAIL stuck_hold: got busy %0b chan %0d want 1 2", o_busy, o_chan); end
`endif
    i_enable = 4'b0000;
    clk_n(4);
  endtask

  task automatic test_polarity;
    int b;
    b = nvalid;
    i_polarity = 4'b0001;
    i_enable   = 4'b0001;
    clk_n(3);
    tick(4'b0001);
    repeat (6) tick(4'b0000);
    repeat (2) tick(4'b0001);
    tick(4'b0000);
    tests++; if (nvalid - b !== 1 || v_chan[b] !== 2'd0) begin fails++; $display("FAIL pol_count: got %0d results chan %0d want 1 chan 0", nvalid - b, v_chan[b]); end
    tests++; if (v_high[b] !== 16'd6 || v_period[b] !== 16'd8) begin fails++; $display("FAIL pol_values: got high %0d period %0d want 6 8", v_high[b], v_period[b]); end
    i_enable   = 4'b0000;
    clk_n(4);
    i_polarity = 4'b0000;
  endtask

  task automatic test_abort_and_ack;
    int b;
    @(negedge i_clk); i_ack = 4'b1111;
    @(negedge i_clk); i_ack = 4'b0000;
    #1;
    tests++; if (o_fresh !== 4'b0000) begin fails++; $display("FAIL ack_all: fresh got %b want 0000", o_fresh); end
    b = nvalid;
    i_enable = 4'b0011;
    clk_n(3);
    tests++; if (o_chan !== 2'd1) begin fails++; $display("FAIL abort_select: chan got %0d want 1", o_chan); end
    tick(4'b0000);
    tick(4'b0010);
    tick(4'b0010);
    i_enable = 4'b0001;
    clk_n(4);
    tests++; if (nvalid - b !== 0 || o_chan !== 2'd0 || o_busy !== 1'b1) begin fails++; $display("FAIL abort_next: got %0d results chan %0d busy %0b want 0 0 1", nvalid - b, o_chan, o_busy); end
    tick(4'b0000);
    tick(4'b0001);
    tick(4'b0000);
    tick(4'b0000);
    @(negedge i_clk); i_pwm = 4'b0001; i_timebase = 1'b1; i_ack = 4'b0001;
    @(negedge i_clk); i_timebase = 1'b0;
    @(negedge i_clk); i_ack = 4'b0000;
    #1;
    tests++; if (nvalid - b !== 1 || v_high[b] !== 16'd1 || v_period[b] !== 16'd3) begin fails++; $display("FAIL ack_store_result: got %0d results high %0d period %0d want 1 1 3", nvalid - b, v_high[b], v_period[b]); end
    tests++; if (o_fresh !== 4'b0001) begin fails++; $display("FAIL ack_collision: fresh got %b want 0001", o_fresh); end
    @(negedge i_clk); i_ack = 4'b0001;
    @(negedge i_clk); i_ack = 4'b0000;
    #1;
    tests++; if (o_fresh !== 4'b0000) begin fails++; $display("FAIL ack_clear: fresh got %b want 0000", o_fresh); end
    i_enable = 4'b0000;
    clk_n(4);
  endtask

  task automatic test_reset_mid;
    int b;
    i_enable = 4'b0110;
    clk_n(3);
    tests++; if (o_chan !== 2'd1) begin fails++; $display("FAIL rst_pre_chan: got %0d want 1", o_chan); end
    tick(4'b0000);
    tick(4'b0010);
    tick(4'b0000);
    @(negedge i_clk); i_rst_n = 1'b0;
    #1;
    tests++; if (o_busy !== 1'b0 || o_chan !== 2'd0 || o_valid !== 1'b0) begin fails++; $display("FAIL rst_mid_ctrl: got busy %0b chan %0d valid %0b want 0 0 0", o_busy, o_chan, o_valid); end
    tests++; if (o_high_time !== 16'd0 || o_period !== 16'd0 || o_valid_chan !== 2'd0) begin fails++; $display("FAIL rst_mid_result: got high %0d period %0d vchan %0d want 0 0 0", o_high_time, o_period, o_valid_chan); end
    tests++; if (o_timeout !== 1'b0 || o_fresh !== 4'b0000) begin fails++; $display("FAIL rst_mid_flags: got tmo %0b fresh %b want 0 0000", o_timeout, o_fresh); end
    clk_n(2);
    @(negedge i_clk); i_rst_n = 1'b1;
    b = nvalid;
    clk_n(3);
    tests++; if (o_chan !== 2'd1 || o_busy !== 1'b1) begin fails++; $display("FAIL rst_restart: got chan %0d busy %0b want 1 1", o_chan, o_busy); end
    tick(4'b0000);
    tick(4'b0010);
    tick(4'b0010);
    tick(4'b0000);
    tick(4'b0000);
    tick(4'b0010);
    tests++; if (nvalid - b !== 1 || v_chan[b] !== 2'd1) begin fails++; $display("FAIL rst_after_count: got %0d results chan %0d want 1 chan 1", nvalid - b, v_chan[b]); end
    tests++; if (v_high[b] !== 16'd2 || v_period[b] !== 16'd4) begin fails++; $display("FAIL rst_after_values: got high %0d period %0d want 2 4", v_high[b], v_period[b]); end
    i_enable = 4'b0000;
    clk_n(4);
  endtask

  initial begin
    test_reset();
    test_single_channel();
    test_round_robin();
    test_stuck_input();
    test_polarity();
    test_abort_and_ack();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
